// File: rtl/led_pkg.sv
// Shared types, default geometry and helpers for the ambilight border sampler.
package led_pkg;

    localparam int PIX_W   = 8;
    localparam int PIX_MAX = (1 << PIX_W) - 1;

    localparam int DEF_H_ACT     = 1920;
    localparam int DEF_V_ACT     = 1080;
    localparam int DEF_BAND      = 20;
    localparam int DEF_N_TB      = 5;
    localparam int DEF_TB_W      = 340;
    localparam int DEF_TB_PITCH  = 395;
    localparam int DEF_N_SD      = 3;
    localparam int DEF_SD_OFF    = 25;
    localparam int DEF_SD_H      = 340;
    localparam int DEF_SD_PITCH  = 345;
    localparam int DEF_DIV_SHIFT = 13;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Region index layout: top edge, then left/right pairs per side row, then bottom edge.
    localparam int TOP_BASE = 0;

    function automatic int side_base(input int n_tb);
        return n_tb;
    endfunction

    function automatic int bot_base(input int n_tb, input int n_sd);
        return n_tb + 2 * n_sd;
    endfunction

    function automatic int n_reg(input int n_tb, input int n_sd);
        return 2 * n_tb + 2 * n_sd;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [PIX_W-1:0] sat_shift(input logic [63:0] sum, input int sh);
        logic [63:0] q;
        q = sum >> sh;
        return (q > 64'(PIX_MAX)) ? {PIX_W{1'b1}} : q[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/led_region_decode.sv
// Combinational (row, col) -> region hit vector for the border sampler.
module led_region_decode
    import led_pkg::*;
#(
    parameter int H_ACT    = DEF_H_ACT,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int BAND     = DEF_BAND,
    parameter int N_TB     = DEF_N_TB,
    parameter int TB_W     = DEF_TB_W,
    parameter int TB_PITCH = DEF_TB_PITCH,
    parameter int N_SD     = DEF_N_SD,
    parameter int SD_OFF   = DEF_SD_OFF,
    parameter int SD_H     = DEF_SD_H,
    parameter int SD_PITCH = DEF_SD_PITCH,
    parameter int RW       = $clog2(DEF_V_ACT),
    parameter int CW       = $clog2(DEF_H_ACT)
) (
    input  logic [RW-1:0]                row_i,
    input  logic [CW-1:0]                col_i,
    output logic [2*N_TB+2*N_SD-1:0]     hit_o
);

    localparam int SIDE0 = side_base(N_TB);
    localparam int BOT0  = bot_base(N_TB, N_SD);

    // Regions must be disjoint and inside the frame.
    if (TB_W > TB_PITCH || (N_TB - 1) * TB_PITCH + TB_W > H_ACT || 2 * BAND > H_ACT ||
        SD_OFF < BAND || SD_H > SD_PITCH ||
        SD_OFF + (N_SD - 1) * SD_PITCH + SD_H > V_ACT - BAND) begin : g_bad_geom
        $error("led_region_decode: overlapping or out-of-frame region geometry");
    end

    int   r, c;
    logic top_band, bot_band, left_band, right_band;

    always_comb begin
        r          = int'(row_i);
        c          = int'(col_i);
        top_band   = r < BAND;
        bot_band   = r >= V_ACT - BAND;
        left_band  = c < BAND;
        right_band = c >= H_ACT - BAND;
    end

    for (genvar k = 0; k < N_TB; k++) begin : g_tb
        localparam int C0 = k * TB_PITCH;
        logic in_cols;
        assign in_cols             = (c >= C0) && (c < C0 + TB_W);
        assign hit_o[TOP_BASE + k] = top_band && in_cols;
        assign hit_o[BOT0 + k]     = bot_band && in_cols;
    end

    for (genvar j = 0; j < N_SD; j++) begin : g_sd
        localparam int R0 = SD_OFF + j * SD_PITCH;
        logic in_rows;
        assign in_rows                  = (r >= R0) && (r < R0 + SD_H);
        assign hit_o[SIDE0 + 2 * j]     = in_rows && left_band;
        assign hit_o[SIDE0 + 2 * j + 1] = in_rows && right_band;
    end

endmodule

// File: rtl/led_region_mean.sv
// Ambilight border sampler: per-region RGB sums over a frame, snapshotted at
// frame end and streamed out as one saturated mean per region.
module led_region_mean
    import led_pkg::*;
#(
    parameter int H_ACT     = DEF_H_ACT,
    parameter int V_ACT     = DEF_V_ACT,
    parameter int BAND      = DEF_BAND,
    parameter int N_TB      = DEF_N_TB,
    parameter int TB_W      = DEF_TB_W,
    parameter int TB_PITCH  = DEF_TB_PITCH,
    parameter int N_SD      = DEF_N_SD,
    parameter int SD_OFF    = DEF_SD_OFF,
    parameter int SD_H      = DEF_SD_H,
    parameter int SD_PITCH  = DEF_SD_PITCH,
    parameter int DIV_SHIFT = DEF_DIV_SHIFT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pix_vld,
    input  logic                               pix_sof,
    input  logic [3*PIX_W-1:0]                 pix_data,
    output logic                               res_vld,
    input  logic                               res_rdy,
    output logic [$clog2(2*N_TB+2*N_SD)-1:0]   res_idx,
    output logic [3*PIX_W-1:0]                 res_rgb,
    output logic                               frame_done,
    output logic                               sync_err,
    output logic                               overrun
);

    localparam int N_REG = n_reg(N_TB, N_SD);
    localparam int IDX_W = $clog2(N_REG);
    localparam int SUM_W = PIX_W + $clog2(max2(BAND * TB_W, BAND * SD_H) + 1);
    localparam int RW    = $clog2(V_ACT);
    localparam int CW    = $clog2(H_ACT);

    logic [RW-1:0] row_q, row_d, row_eff;
    logic [CW-1:0] col_q, col_d, col_eff;
    logic          desync, last_px;

    always_comb begin
        row_eff = pix_sof ? '0 : row_q;
        col_eff = pix_sof ? '0 : col_q;
        desync  = pix_vld && pix_sof && (row_q != '0 || col_q != '0);
        last_px = pix_vld && (row_eff == RW'(V_ACT - 1)) && (col_eff == CW'(H_ACT - 1));
        row_d   = row_q;
        col_d   = col_q;
        if (pix_vld) begin
            if (col_eff == CW'(H_ACT - 1)) begin
                col_d = '0;
                row_d = (row_eff == RW'(V_ACT - 1)) ? '0 : row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    logic [N_REG-1:0] hit;

    led_region_decode #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .BAND    (BAND),
        .N_TB    (N_TB),
        .TB_W    (TB_W),
        .TB_PITCH(TB_PITCH),
        .N_SD    (N_SD),
        .SD_OFF  (SD_OFF),
        .SD_H    (SD_H),
        .SD_PITCH(SD_PITCH),
        .RW      (RW),
        .CW      (CW)
    ) u_decode (
        .row_i(row_eff),
        .col_i(col_eff),
        .hit_o(hit)
    );

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    rgb_t             rgb_q, rgb_d;
    logic             fdone_q, serr_q, ovr_q, ovr_d;
    logic             last_hs, idle_eff, snap;

    // Channel index 2 = R, 1 = G, 0 = B, matching the bit order of pix_data.
    logic [N_REG-1:0][2:0][SUM_W-1:0] live_q, live_d, shadow_q, shadow_d, sum_nxt;

    always_comb begin
        last_hs  = (state_q == ST_SEND) && res_rdy && (idx_q == IDX_W'(N_REG - 1));
        // The final handshake frees the shadow bank in the same cycle.
        idle_eff = (state_q == ST_IDLE) || last_hs;
        snap     = last_px && idle_eff;
        ovr_d    = ovr_q | (last_px && !idle_eff);
        state_d  = state_q;
        idx_d    = idx_q;
        if (snap) begin
            state_d = ST_SEND;
            idx_d   = '0;
        end else if (last_hs) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (state_q == ST_SEND && res_rdy) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_comb begin
        sum_nxt = '0;
        for (int i = 0; i < N_REG; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                sum_nxt[i][ch] = (desync ? '0 : live_q[i][ch]) +
                                 ((pix_vld && hit[i]) ? SUM_W'(pix_data[ch*PIX_W +: PIX_W]) : '0);
            end
        end
        live_d   = last_px ? '0 : sum_nxt;
        shadow_d = snap ? sum_nxt : shadow_q;
    end

    always_comb begin
        rgb_d = '0;
        if (state_d == ST_SEND) begin
            rgb_d.r = sat_shift(64'(shadow_d[idx_d][2]), DIV_SHIFT);
            rgb_d.g = sat_shift(64'(shadow_d[idx_d][1]), DIV_SHIFT);
            rgb_d.b = sat_shift(64'(shadow_d[idx_d][0]), DIV_SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            col_q    <= '0;
            live_q   <= '0;
            shadow_q <= '0;
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rgb_q    <= '0;
            fdone_q  <= 1'b0;
            serr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            live_q   <= live_d;
            shadow_q <= shadow_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            rgb_q    <= rgb_d;
            fdone_q  <= snap;
            serr_q   <= desync;
            ovr_q    <= ovr_d;
        end
    end

    assign res_vld    = (state_q == ST_SEND);
    assign res_idx    = idx_q;
    assign res_rgb    = rgb_q;
    assign frame_done = fdone_q;
    assign sync_err   = serr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_led_region_mean.sv
// Bench for led_region_mean on a reduced 64x40 geometry with 16 regions.
module tb_led_region_mean;

    localparam int H_ACT = 64, V_ACT = 40, BAND = 2;
    localparam int N_TB = 5, TB_W = 10, TB_PITCH = 13;
    localparam int N_SD = 3, SD_OFF = 3, SD_H = 10, SD_PITCH = 11;
    localparam int DIV_SHIFT = 4;
    localparam int N_REG = 2 * N_TB + 2 * N_SD;

    logic        clk = 0, rst_n = 0, pix_vld = 0, pix_sof = 0, res_rdy = 0;
    logic [23:0] pix_data = '0;
    logic        res_vld, frame_done, sync_err, overrun;
    logic [3:0]  res_idx;
    logic [23:0] res_rgb;

    always #5 clk = ~clk;

    led_region_mean #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .BAND(BAND), .N_TB(N_TB), .TB_W(TB_W),
        .TB_PITCH(TB_PITCH), .N_SD(N_SD), .SD_OFF(SD_OFF), .SD_H(SD_H),
        .SD_PITCH(SD_PITCH), .DIV_SHIFT(DIV_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_vld(pix_vld), .pix_sof(pix_sof),
        .pix_data(pix_data), .res_vld(res_vld), .res_rdy(res_rdy),
        .res_idx(res_idx), .res_rgb(res_rgb), .frame_done(frame_done),
        .sync_err(sync_err), .overrun(overrun)
    );

    typedef struct packed { logic [3:0] idx; logic [23:0] rgb; } res_t;
    typedef struct { logic [23:0] fill; logic [23:0] expv; } vec_t;

    int          n_chk = 0, n_pass = 0, fd_cnt = 0, se_cnt = 0;
    bit          rdy_rand = 0;
    logic [23:0] fr [V_ACT][H_ACT];
    logic [23:0] exp_a [N_REG];
    res_t        resq[$];
    logic        p_stall = 0;
    logic [3:0]  p_idx = '0;
    logic [23:0] p_rgb = '0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (p_stall)
                chk(res_vld && res_idx == p_idx && res_rgb == p_rgb, "stall_stable",
                    32'({res_vld, res_idx, res_rgb}), 32'({1'b1, p_idx, p_rgb}));
            if (res_vld && res_rdy) resq.push_back(res_t'({res_idx, res_rgb}));
            if (frame_done) fd_cnt <= fd_cnt + 1;
            if (sync_err) se_cnt <= se_cnt + 1;
            p_stall <= res_vld && !res_rdy;
            p_idx   <= res_idx;
            p_rgb   <= res_rgb;
        end else begin
            p_stall <= 1'b0;
        end
    end

    always @(posedge clk) if (rdy_rand) begin #1; res_rdy = 1'($urandom_range(0, 1)); end

    task automatic drive_px(input logic [23:0] d, input logic sof);
        @(posedge clk); #1;
        pix_vld = 1; pix_sof = sof; pix_data = d;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        pix_vld = 0; pix_sof = 0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < V_ACT; r++)
            for (int c = 0; c < H_ACT; c++) begin
                if (gaps && $urandom_range(0, 7) == 0) go_idle();
                drive_px(fr[r][c], r == 0 && c == 0);
            end
        go_idle();
    endtask

    task automatic fill(input logic [23:0] v);
        for (int r = 0; r < V_ACT; r++)
            for (int c = 0; c < H_ACT; c++) fr[r][c] = v;
    endtask

    // Reference: sum each region's rectangle straight from the frame store.
    task automatic model();
        int r0, r1, c0, c1, j, m;
        int s [3];
        for (int i = 0; i < N_REG; i++) begin
            if (i < N_TB) begin
                r0 = 0; r1 = BAND; c0 = i * TB_PITCH; c1 = c0 + TB_W;
            end else if (i >= N_TB + 2 * N_SD) begin
                r0 = V_ACT - BAND; r1 = V_ACT;
                c0 = (i - N_TB - 2 * N_SD) * TB_PITCH; c1 = c0 + TB_W;
            end else begin
                j = (i - N_TB) / 2;
                r0 = SD_OFF + j * SD_PITCH; r1 = r0 + SD_H;
                if ((i - N_TB) % 2 == 0) begin c0 = 0; c1 = BAND; end
                else begin c0 = H_ACT - BAND; c1 = H_ACT; end
            end
            s = '{0, 0, 0};
            for (int r = r0; r < r1; r++)
                for (int c = c0; c < c1; c++)
                    for (int ch = 0; ch < 3; ch++) s[ch] += int'(fr[r][c][ch*8 +: 8]);
            for (int ch = 0; ch < 3; ch++) begin
                m = s[ch] >> DIV_SHIFT;
                exp_a[i][ch*8 +: 8] = (m > 255) ? 8'hFF : 8'(m);
            end
        end
    endtask

    task automatic wait_vld(input string nm);
        int n = 0;
        @(negedge clk);
        while (!res_vld && n < 100) begin @(negedge clk); n++; end
        chk(res_vld, nm, 32'(res_vld), 1);
    endtask

    task automatic check_results(input string nm);
        int   n = 0;
        res_t rr;
        while (resq.size() < N_REG && n < 400) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk(resq.size() == N_REG, {nm, "_count"}, resq.size(), N_REG);
        for (int i = 0; i < N_REG && resq.size() > 0; i++) begin
            rr = resq.pop_front();
            chk(rr.idx == 4'(i) && rr.rgb == exp_a[i], {nm, "_result"},
                32'({rr.idx, rr.rgb}), 32'({4'(i), exp_a[i]}));
        end
        resq.delete();
        chk(!res_vld, {nm, "_idle"}, 32'(res_vld), 0);
    endtask

    initial begin
        vec_t tbl [6];
        int   fd0, se0, n;
        tbl[0] = '{24'h101010, 24'h141414};
        tbl[1] = '{24'hFFFFFF, 24'hFFFFFF};
        tbl[2] = '{24'hCC3201, 24'hFF3E01};
        tbl[3] = '{24'hCD0000, 24'hFF0000};
        tbl[4] = '{24'h000000, 24'h000000};
        tbl[5] = '{24'h0C0D0E, 24'h0F1011};

        repeat (3) @(negedge clk);
        chk(!res_vld, "rst_res_vld", 32'(res_vld), 0);
        chk(res_idx == 0, "rst_res_idx", 32'(res_idx), 0);
        chk(res_rgb == 0, "rst_res_rgb", 32'(res_rgb), 0);
        chk(!frame_done && !sync_err, "rst_pulses", 32'({frame_done, sync_err}), 0);
        chk(!overrun, "rst_overrun", 32'(overrun), 0);
        @(posedge clk); #1;
        rst_n = 1; res_rdy = 1;

        for (int v = 0; v < 6; v++) begin
            fill(tbl[v].fill);
            for (int i = 0; i < N_REG; i++) exp_a[i] = tbl[v].expv;
            fd0 = fd_cnt;
            send_frame(0);
            @(negedge clk);
            chk(frame_done && res_vld && res_idx == 0, "snap_latency",
                32'({frame_done, res_vld, res_idx}), 32'(6'b110000));
            check_results("table");
            chk(fd_cnt == fd0 + 1, "frame_done_once", fd_cnt - fd0, 1);
        end
        chk(se_cnt == 0, "no_sync_err", se_cnt, 0);
        chk(!overrun, "no_overrun", 32'(overrun), 0);

        // Only gap pixels lit.
        fill(24'h000000);
        for (int c = 10; c < 13; c++) fr[0][c] = 24'hFFFFFF;
        for (int c = 23; c < 26; c++) fr[1][c] = 24'hFFFFFF;
        fr[0][62] = 24'hFFFFFF; fr[20][30] = 24'hFFFFFF;
        fr[13][0] = 24'hFFFFFF; fr[36][5] = 24'hFFFFFF; fr[39][63] = 24'hFFFFFF;
        model();
        send_frame(0);
        check_results("gap");

        // Long stall then toggling ready.
        fill(24'h101010); model();
        res_rdy = 0;
        send_frame(0);
        wait_vld("stall_vld");
        repeat (10) begin
            @(negedge clk);
            chk(res_vld && res_idx == 0 && res_rgb == exp_a[0], "stall_hold0",
                32'({res_vld, res_idx, res_rgb}), 32'({1'b1, 4'd0, exp_a[0]}));
        end
        n = 0;
        while (resq.size() < N_REG && n < 200) begin
            @(posedge clk); #1;
            res_rdy = ~res_rdy; n++;
        end
        res_rdy = 1;
        check_results("stall");

        // Second frame end while still sending.
        res_rdy = 0; fd0 = fd_cnt;
        fill(24'h101010); model();
        send_frame(0);
        fill(24'hFFFFFF);
        send_frame(0);
        repeat (2) @(negedge clk);
        chk(fd_cnt == fd0 + 1, "ovr_single_done", fd_cnt - fd0, 1);
        chk(overrun, "overrun_set", 32'(overrun), 1);
        res_rdy = 1;
        check_results("overrun");
        chk(overrun, "overrun_sticky", 32'(overrun), 1);

        // Early start-of-frame mid-frame.
        se0 = se_cnt;
        for (int p = 0; p < 1000; p++) drive_px(24'hFFFFFF, p == 0);
        fill(24'h101010); model();
        send_frame(0);
        check_results("sync");
        chk(se_cnt == se0 + 1, "sync_err_once", se_cnt - se0, 1);

        // Reset in the middle of a result stream.
        res_rdy = 0;
        send_frame(0);
        wait_vld("rst_vld");
        @(posedge clk); #1;
        res_rdy = 1;
        repeat (7) @(posedge clk);
        #1 res_rdy = 0;
        @(negedge clk);
        chk(res_vld && res_idx == 7, "idx_before_rst", 32'({res_vld, res_idx}), 32'({1'b1, 4'd7}));
        #2 rst_n = 0;
        #1;
        chk(!res_vld && res_idx == 0, "rst_mid_vld_idx", 32'({res_vld, res_idx}), 0);
        chk(res_rgb == 0, "rst_mid_rgb", 32'(res_rgb), 0);
        chk(!overrun && !frame_done && !sync_err, "rst_mid_flags",
            32'({overrun, frame_done, sync_err}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        resq.delete();
        res_rdy = 1;
        fill(24'h0C0D0E); model();
        send_frame(0);
        check_results("post_rst");

        // Random frames, random valid gaps, random ready.
        rdy_rand = 1;
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < V_ACT; r++)
                for (int c = 0; c < H_ACT; c++) fr[r][c] = 24'($urandom);
            model();
            send_frame(1);
            check_results("random");
        end
        rdy_rand = 0;
        chk(!overrun, "random_no_overrun", 32'(overrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_region_mean.md
Name: led_region_mean

Overview:
- Ambilight border sampler. Accumulates per-region RGB sums over a streamed video frame for N_TB top, N_TB bottom and 2*N_SD side regions.
- At each frame end it snapshots the sums into a shadow bank, divides them by a power of two, and streams one mean RGB word per region over a valid/ready interface to the LED driver.
- Sits between the video input timing stage and the LED colour mapper.

Parameters:
- H_ACT, 1920, active pixels per line
- V_ACT, 1080, active lines per frame
- PIX_W, 8, bits per colour channel (all bits used)
- BAND, 20, border thickness in pixels (rows for top/bottom, cols for sides)
- N_TB, 5, regions along top edge (same count on bottom)
- TB_W, 340, top/bottom region width; TB_PITCH, 395, start-to-start column pitch
- N_SD, 3, regions per side edge
- SD_OFF, 25, first side region start row; SD_H, 340, side region height; SD_PITCH, 345, row pitch
- DIV_SHIFT, 13, mean = sum >> DIV_SHIFT
- N_REG (derived), 2*N_TB+2*N_SD = 16
- SUM_W (derived), PIX_W + clog2(max(BAND*TB_W, BAND*SD_H)+1) = 21

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- pix_vld  in  1  pixel qualifier
- pix_sof  in  1  first pixel of frame (qualified by pix_vld)
- pix_data  in  3*PIX_W  {R,G,B}, R in MSBs
- res_vld  out  1  result valid
- res_rdy  in  1  result accept
- res_idx  out  clog2(N_REG)  region index of current result
- res_rgb  out  3*PIX_W  mean {R,G,B}
- frame_done  out  1  one-cycle pulse when a snapshot is taken
- sync_err  out  1  one-cycle pulse on unexpected pix_sof
- overrun  out  1  sticky, set when a snapshot is dropped

Behaviour:
- Reset (async): row/col counters 0; live and shadow sums 0; FSM IDLE; res_vld, frame_done, sync_err, overrun 0; res_idx 0; res_rgb 0. Reset mid-SEND abandons the stream immediately.
- Position: col increments on each pix_vld. At H_ACT-1 col wraps to 0 and row increments. At (V_ACT-1, H_ACT-1) both wrap.
- Region map, half-open ranges:
  - Top k: rows [0,BAND), cols [k*TB_PITCH, k*TB_PITCH+TB_W) -> idx k.
  - Side j: rows [SD_OFF+j*SD_PITCH, +SD_H). Left cols [0,BAND) -> idx N_TB+2j. Right cols [H_ACT-BAND, H_ACT) -> idx N_TB+2j+1.
  - Bottom k: rows [V_ACT-BAND, V_ACT), same cols as top -> idx N_TB+2*N_SD+k.
  - Pixels in gaps are ignored. Regions must not overlap (parameter legality; elaborate-time assertion).
- Accumulate: on pix_vld, every matching region adds each channel to its SUM_W live sum. Sums cannot overflow by construction.
- Frame end (pix_vld at the last pixel):
  - The last pixel's contribution is included.
  - If FSM is IDLE: shadow <= live + contribution; live cleared; FSM -> SEND. frame_done and res_vld rise on the next cycle with res_idx=0.
  - If FSM is SEND: live is still cleared, shadow is untouched, frame_done stays 0, and overrun is set (sticky until reset).
- pix_sof with pix_vld:
  - The pixel is treated as (0,0) and counters continue from (0,1).
  - If the counters were not already at (0,0): live sums are cleared before this pixel accumulates, and sync_err pulses on the next cycle.
  - Shadow and SEND are unaffected.
- FSM states: IDLE, SEND.
  - In SEND: res_vld=1. res_rgb[ch] = sat(shadow[res_idx][ch] >> DIV_SHIFT), where sat yields all-ones if the result does not fit in PIX_W.
  - res_rgb and res_idx are registered and stay stable while res_vld && !res_rdy.
  - On each handshake res_idx increments; back-to-back accepts give one result per cycle.
  - Handshake at idx N_REG-1 -> IDLE; res_vld=0 and res_idx=0 next cycle.
- Simultaneous events: a frame end on the same cycle as the final handshake takes a normal snapshot (FSM treated as IDLE) with no overrun.

Decomposition:
- Package led_pkg: rgb_t (PIX_W per channel), default geometry constants, region index enum/offsets (TOP_BASE, SIDE_BASE, BOT_BASE), sat_shift function.
- One sub-module led_region_decode: combinational (row, col) -> N_REG-bit hit vector, parametrised on the geometry.
- Top level holds counters, accumulators, shadow bank and FSM.

Test Plan:
- Default params, full frame all 0x101010, res_rdy=1 -> frame_done once; 16 results idx 0..15 on consecutive cycles; each res_rgb = 0x0D0D0D (6800*16 >> 13 = 13).
- Full frame all 0xFFFFFF -> every region 0xD3D3D3 (1734000 >> 13 = 211); DIV_SHIFT=0 variant -> 0xFFFFFF (saturated).
- Frame with only gap pixels (e.g. row 0 cols 340..394, row 500 col 960) = 0xFFFFFF, rest 0 -> all 16 results 0x000000.
- res_rdy low 10 cycles after res_vld, then toggling 1/0 -> res_idx/res_rgb stable while stalled; exactly 16 handshakes, in order.
- res_rdy held 0 across two frame ends (frame1 0x101010, frame2 0xFFFFFF) -> no second frame_done; overrun=1; released results all 0x0D0D0D.
- pix_sof at pixel 1000 of a frame -> sync_err one pulse; the following full 0x101010 frame yields 0x0D0D0D. Separately, rst_n low during SEND at idx 7 -> res_vld=0 at once and all outputs at reset values; next frame correct.
